// File: rtl/port_sram_matcher_pkg.sv
// Shared types and sizing for the SRAM pool allocators.
package hydra_pkg;

  localparam int NUM_SRAM   = 32;
  localparam int FREE_W     = 11;
  localparam int PAGE_SHIFT = 3;
  localparam int PORT_W     = 4;
  localparam int LEN_W      = 9;
  localparam int SW         = $clog2(NUM_SRAM);

  typedef logic [SW-1:0]     sram_idx_t;
  typedef logic [FREE_W-1:0] free_t;

  typedef enum logic [1:0] {IDLE, SCAN, LOCK, DONE} match_state_e;

  // Round the word count up to whole pages; an empty packet still occupies one page.
  function automatic free_t calc_need_pages(input logic [LEN_W-1:0] len);
    logic [9:0] sum;
    sum = {1'b0, len} + 10'((1 << PAGE_SHIFT) - 1);
    sum = sum >> PAGE_SHIFT;
    if (sum == '0) sum = 10'd1;
    return free_t'(sum);
  endfunction

endpackage

// File: rtl/port_sram_matcher_if.sv
// Frontend request/response and lock-arbiter handshake of one port's SRAM matcher.
interface port_sram_matcher_if;
  import hydra_pkg::*;

  logic                       match_enable;
  logic [PORT_W-1:0]          new_dest_port;
  logic [LEN_W-1:0]           new_length;
  logic [NUM_SRAM*FREE_W-1:0] sram_free;
  logic [NUM_SRAM-1:0]        sram_locked;
  logic                       lock_req;
  sram_idx_t                  lock_sram;
  logic                       lock_gnt;
  logic                       lock_nack;
  logic                       match_end;
  sram_idx_t                  matched_sram;
  logic [PORT_W-1:0]          matched_dest;

  modport master (
    output match_enable, new_dest_port, new_length, sram_free, sram_locked, lock_gnt, lock_nack,
    input  lock_req, lock_sram, match_end, matched_sram, matched_dest
  );

  modport slave (
    input  match_enable, new_dest_port, new_length, sram_free, sram_locked, lock_gnt, lock_nack,
    output lock_req, lock_sram, match_end, matched_sram, matched_dest
  );

endinterface

// File: rtl/port_sram_matcher_sram_best_tracker.sv
// Holds the best (index, free) candidate seen so far; a later candidate must be strictly larger.
module sram_best_tracker
  import hydra_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clear_i,
  input  logic      valid_i,
  input  sram_idx_t idx_i,
  input  free_t     free_i,
  output logic      best_vld_next_o,
  output sram_idx_t best_idx_o
);

  logic      best_vld_q, best_vld_d;
  sram_idx_t best_idx_q, best_idx_d;
  free_t     best_free_q, best_free_d;
  logic      take;

  always_comb begin
    take        = valid_i && (!best_vld_q || (free_i > best_free_q));
    best_vld_d  = best_vld_q;
    best_idx_d  = best_idx_q;
    best_free_d = best_free_q;
    if (clear_i) begin
      best_vld_d = 1'b0;
    end else if (take) begin
      best_vld_d  = 1'b1;
      best_idx_d  = idx_i;
      best_free_d = free_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_vld_q  <= 1'b0;
      best_idx_q  <= '0;
      best_free_q <= '0;
    end else begin
      best_vld_q  <= best_vld_d;
      best_idx_q  <= best_idx_d;
      best_free_q <= best_free_d;
    end
  end

  // The end-of-pass decision must include the bank examined in that same cycle.
  assign best_vld_next_o = best_vld_d;
  assign best_idx_o      = best_idx_q;

endmodule

// File: rtl/port_sram_matcher.sv
// Per-port SRAM allocator: scans all banks one per cycle, picks the roomiest eligible one, locks it.
module port_sram_matcher
  import hydra_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  port_sram_matcher_if.slave  mif
);

  match_state_e      state_q, state_d;
  sram_idx_t         idx_q, idx_d;
  free_t             need_q, need_d;
  logic [PORT_W-1:0] dest_q, dest_d;
  sram_idx_t         matched_q, matched_d;
  logic              arm_q, arm_d;

  free_t     cur_free;
  logic      eligible;
  logic      last_idx;
  logic      trk_clear;
  logic      best_vld_next;
  sram_idx_t best_idx;

  assign cur_free = mif.sram_free[idx_q*FREE_W +: FREE_W];
  assign eligible = !mif.sram_locked[idx_q] && (cur_free >= need_q);
  assign last_idx = (idx_q == sram_idx_t'(NUM_SRAM - 1));

  sram_best_tracker u_tracker (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear_i         (trk_clear),
    .valid_i         ((state_q == SCAN) && eligible),
    .idx_i           (idx_q),
    .free_i          (cur_free),
    .best_vld_next_o (best_vld_next),
    .best_idx_o      (best_idx)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    need_d    = need_q;
    dest_d    = dest_q;
    matched_d = matched_q;
    trk_clear = 1'b0;
    // A completed request re-arms only after the frontend has dropped match_enable.
    arm_d     = arm_q | ~mif.match_enable;
    case (state_q)
      IDLE: begin
        trk_clear = 1'b1;
        idx_d     = '0;
        if (mif.match_enable && arm_q) begin
          need_d  = calc_need_pages(mif.new_length);
          dest_d  = mif.new_dest_port;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!mif.match_enable) begin
          state_d = IDLE;
        end else if (last_idx) begin
          idx_d = '0;
          if (best_vld_next) state_d = LOCK;
        end else begin
          idx_d = sram_idx_t'(idx_q + 1'b1);
        end
      end
      LOCK: begin
        // A grant is honoured even when the frontend aborts in the same cycle.
        if (mif.lock_gnt) begin
          matched_d = best_idx;
          state_d   = DONE;
        end else if (!mif.match_enable) begin
          state_d = IDLE;
        end else if (mif.lock_nack) begin
          trk_clear = 1'b1;
          idx_d     = '0;
          state_d   = SCAN;
        end
      end
      DONE: begin
        arm_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      need_q    <= '0;
      dest_q    <= '0;
      matched_q <= '0;
      arm_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      need_q    <= need_d;
      dest_q    <= dest_d;
      matched_q <= matched_d;
      arm_q     <= arm_d;
    end
  end

  assign mif.lock_req     = (state_q == LOCK);
  assign mif.lock_sram    = (state_q == LOCK) ? best_idx : '0;
  assign mif.match_end    = (state_q == DONE);
  assign mif.matched_sram = matched_q;
  assign mif.matched_dest = dest_q;

endmodule

// File: tb/tb_port_sram_matcher.sv
// Directed scenarios for port_sram_matcher with hand-computed cycle counts and bank choices.
module tb_port_sram_matcher;
  import hydra_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  port_sram_matcher_if bus ();

  port_sram_matcher dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mif   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_all_free(input int v);
    for (int i = 0; i < NUM_SRAM; i++) bus.sram_free[i*FREE_W +: FREE_W] = free_t'(v);
  endtask

  task automatic set_free(input int i, input int v);
    bus.sram_free[i*FREE_W +: FREE_W] = free_t'(v);
  endtask

  task automatic idle(input int n);
    bus.match_enable = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_req(input int len, input int dest);
    bus.new_length    = LEN_W'(len);
    bus.new_dest_port = PORT_W'(dest);
    bus.match_enable  = 1'b1;
  endtask

  task automatic wait_lock(input int budget, inout int cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.lock_req) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic grant(output logic me);
    bus.lock_gnt = 1'b1;
    @(posedge clk);
    #1;
    me               = bus.match_end;
    bus.lock_gnt     = 1'b0;
    bus.lock_nack    = 1'b0;
    bus.match_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.lock_req !== 1'b0 || bus.match_end !== 1'b0 || bus.lock_sram !== '0 ||
        bus.matched_sram !== '0 || bus.matched_dest !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%0d end=%0d lsram=%0d msram=%0d mdest=%0d expected all 0",
               bus.lock_req, bus.match_end, bus.lock_sram, bus.matched_sram, bus.matched_dest);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc; bit to; logic me;
    set_all_free(100);
    bus.sram_locked = '0;
    idle(2);
    start_req(64, 3);
    cyc = 0;
    wait_lock(100, cyc, to);
    checks++;
    if (to || cyc != 33 || bus.lock_sram !== 5'd0) begin
      failures++;
      $display("FAIL basic_lock: got cyc=%0d sram=%0d timeout=%0d expected cyc=33 sram=0", cyc, bus.lock_sram, to);
    end
    grant(me);
    checks++;
    if (me !== 1'b1 || bus.matched_sram !== 5'd0 || bus.matched_dest !== 4'd3) begin
      failures++;
      $display("FAIL basic_match_end: got end=%0d msram=%0d mdest=%0d expected 1/0/3", me, bus.matched_sram, bus.matched_dest);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.match_end !== 1'b0 || bus.lock_req !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse_width: got end=%0d req=%0d expected 0/0", bus.match_end, bus.lock_req);
    end
  endtask

  task automatic test_tie();
    int cyc; bit to; logic me;
    set_all_free(50);
    set_free(5, 900);
    set_free(17, 900);
    idle(2);
    start_req(64, 1);
    cyc = 0;
    wait_lock(100, cyc, to);
    checks++;
    if (to || bus.lock_sram !== 5'd5) begin
      failures++;
      $display("FAIL tie_lower_index: got sram=%0d timeout=%0d expected 5", bus.lock_sram, to);
    end
    bus.lock_nack = 1'b1;
    grant(me);
    checks++;
    if (me !== 1'b1 || bus.matched_sram !== 5'd5) begin
      failures++;
      $display("FAIL gnt_wins_over_nack: got end=%0d msram=%0d expected 1/5", me, bus.matched_sram);
    end
    bus.sram_locked[5] = 1'b1;
    idle(2);
    start_req(64, 2);
    cyc = 0;
    wait_lock(100, cyc, to);
    checks++;
    if (to || bus.lock_sram !== 5'd17) begin
      failures++;
      $display("FAIL tie_locked_skip: got sram=%0d timeout=%0d expected 17", bus.lock_sram, to);
    end
    grant(me);
    bus.sram_locked = '0;
  endtask

  task automatic test_rearm();
    int cyc; bit to; logic me; int seen;
    set_all_free(100);
    idle(2);
    start_req(64, 4);
    cyc = 0;
    wait_lock(100, cyc, to);
    bus.lock_gnt = 1'b1;
    @(posedge clk);
    #1;
    bus.lock_gnt = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.lock_req) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rearm_blocked: got %0d lock_req cycles expected 0", seen);
    end
    idle(1);
    start_req(64, 4);
    cyc = 0;
    wait_lock(100, cyc, to);
    checks++;
    if (to || cyc != 33) begin
      failures++;
      $display("FAIL rearm_latency: got cyc=%0d timeout=%0d expected 33", cyc, to);
    end
    grant(me);
  endtask

  task automatic test_retry();
    int cyc; bit to; logic me; int seen;
    set_all_free(3);
    idle(2);
    start_req(40, 6);
    cyc  = 0;
    seen = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.lock_req) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL retry_no_lock: got %0d lock_req cycles expected 0", seen);
    end
    set_free(9, 10);
    wait_lock(100, cyc, to);
    checks++;
    if (to || cyc != 97 || bus.lock_sram !== 5'd9) begin
      failures++;
      $display("FAIL retry_lock: got cyc=%0d sram=%0d timeout=%0d expected cyc=97 sram=9", cyc, bus.lock_sram, to);
    end
    grant(me);
    checks++;
    if (me !== 1'b1 || bus.matched_sram !== 5'd9) begin
      failures++;
      $display("FAIL retry_match_end: got end=%0d msram=%0d expected 1/9", me, bus.matched_sram);
    end
  endtask

  task automatic test_nack();
    int cyc; bit to; logic me;
    set_all_free(2);
    set_free(4, 500);
    set_free(20, 300);
    idle(2);
    start_req(64, 7);
    cyc = 0;
    wait_lock(100, cyc, to);
    checks++;
    if (to || cyc != 33 || bus.lock_sram !== 5'd4) begin
      failures++;
      $display("FAIL nack_first_lock: got cyc=%0d sram=%0d timeout=%0d expected cyc=33 sram=4", cyc, bus.lock_sram, to);
    end
    bus.lock_nack      = 1'b1;
    bus.sram_locked[4] = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    bus.lock_nack = 1'b0;
    checks++;
    if (bus.lock_req !== 1'b0) begin
      failures++;
      $display("FAIL nack_drop: got req=%0d expected 0", bus.lock_req);
    end
    wait_lock(100, cyc, to);
    checks++;
    if (to || cyc != 66 || bus.lock_sram !== 5'd20) begin
      failures++;
      $display("FAIL nack_relock: got cyc=%0d sram=%0d timeout=%0d expected cyc=66 sram=20", cyc, bus.lock_sram, to);
    end
    grant(me);
    checks++;
    if (me !== 1'b1 || bus.matched_sram !== 5'd20) begin
      failures++;
      $display("FAIL nack_match_end: got end=%0d msram=%0d expected 1/20", me, bus.matched_sram);
    end
    bus.sram_locked = '0;
  endtask

  task automatic test_boundary();
    int cyc; bit to; logic me; int seen;
    int lens [2] = '{0, 511};
    int base [2] = '{0, 63};
    int bank [2] = '{7, 11};
    for (int t = 0; t < 2; t++) begin
      set_all_free(base[t]);
      idle(2);
      start_req(lens[t], 5);
      seen = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (bus.lock_req) seen++;
      end
      checks++;
      if (seen != 0) begin
        failures++;
        $display("FAIL boundary_len%0d_none: got %0d lock_req cycles expected 0", lens[t], seen);
      end
      set_free(bank[t], base[t] + 1);
      cyc = 0;
      wait_lock(100, cyc, to);
      checks++;
      if (to || bus.lock_sram !== sram_idx_t'(bank[t])) begin
        failures++;
        $display("FAIL boundary_len%0d_lock: got sram=%0d timeout=%0d expected %0d", lens[t], bus.lock_sram, to, bank[t]);
      end
      grant(me);
    end
  endtask

  task automatic test_abort();
    int cyc; bit to; int seen;
    set_all_free(100);
    set_free(20, 200);
    idle(2);
    start_req(64, 9);
    repeat (13) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (dut.idx_q !== 5'd12) begin
      failures++;
      $display("FAIL abort_at_idx12: got idx=%0d expected 12", dut.idx_q);
    end
    bus.match_enable = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dut.state_q !== IDLE || bus.lock_req !== 1'b0 || bus.match_end !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: got state=%0d req=%0d end=%0d expected %0d/0/0", dut.state_q, bus.lock_req, bus.match_end, IDLE);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.lock_req || bus.match_end) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", seen);
    end
    start_req(64, 9);
    cyc = 0;
    wait_lock(100, cyc, to);
    checks++;
    if (to || cyc != 33 || bus.lock_sram !== 5'd20) begin
      failures++;
      $display("FAIL abort_rescan: got cyc=%0d sram=%0d timeout=%0d expected cyc=33 sram=20", cyc, bus.lock_sram, to);
    end
  endtask

  task automatic test_reset_mid();
    checks++;
    if (bus.lock_req !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre: got req=%0d expected 1", bus.lock_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.lock_req !== 1'b0 || bus.lock_sram !== '0 || bus.match_end !== 1'b0 ||
        bus.matched_sram !== '0 || bus.matched_dest !== '0 || dut.state_q !== IDLE) begin
      failures++;
      $display("FAIL reset_mid: got req=%0d lsram=%0d end=%0d msram=%0d mdest=%0d state=%0d expected all 0",
               bus.lock_req, bus.lock_sram, bus.match_end, bus.matched_sram, bus.matched_dest, dut.state_q);
    end
    bus.match_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    bus.match_enable  = 1'b0;
    bus.new_dest_port = '0;
    bus.new_length    = '0;
    bus.sram_free     = '0;
    bus.sram_locked   = '0;
    bus.lock_gnt      = 1'b0;
    bus.lock_nack     = 1'b0;
    test_reset();
    test_basic();
    test_tie();
    test_rearm();
    test_retry();
    test_nack();
    test_boundary();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
